// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the single-outstanding memory bus initiator.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } mem_bus_state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 7;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_bus_initiator.sv
// Load/store initiator for the CPU-side virtual memory bus: one transaction in
// flight, registered bus outputs, fixed-latency synchronous read capture.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] addressVirt,
  output logic [31:0] dataInVirt,
  output logic        wEnVirt,
  output logic        rstVirt,
  input  logic [31:0] dataOutVirt
);

  // Out-of-range latencies are clamped so the 3-bit counter never loads 0.
  localparam int unsigned LAT_CLAMPED =
    (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
    (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
  localparam logic [2:0] LAT_INIT = 3'(LAT_CLAMPED);

  mem_bus_state_e state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           wen_q, wen_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!is_word_aligned(req_addr)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (req_we) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wen_d   = 1'b1;
            err_d   = 1'b0;
            rdata_d = '0;
            state_d = WRITE;
          end else begin
            addr_d  = req_addr;
            cnt_d   = LAT_INIT;
            err_d   = 1'b0;
            rdata_d = '0;
            state_d = READ_WAIT;
          end
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      READ_WAIT: begin
        if (cnt_q == 3'd1) begin
          rdata_d = dataOutVirt;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign addressVirt = addr_q;
  assign dataInVirt  = wdata_q;
  assign wEnVirt     = wen_q;
  assign rstVirt     = rst;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Self-checking bench for mem_bus_initiator: directed table, random traffic
// against a transaction-level memory model, and multi-cycle corner sequences.
module tb_mem_bus_initiator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // READ_LATENCY = 1 instance
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] addressVirt, dataInVirt, dataOutVirt;
  logic        wEnVirt, rstVirt;

  // READ_LATENCY = 4 instance
  logic        r4_valid, r4_ready, r4_we;
  logic [31:0] r4_addr, r4_wdata;
  logic        s4_valid, s4_ready, s4_err;
  logic [31:0] s4_rdata, a4, di4, d4_dout;
  logic        we4, rv4;

  mem_bus_initiator #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addressVirt(addressVirt), .dataInVirt(dataInVirt),
    .wEnVirt(wEnVirt), .rstVirt(rstVirt), .dataOutVirt(dataOutVirt)
  );

  mem_bus_initiator #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(r4_valid), .req_ready(r4_ready), .req_we(r4_we),
    .req_addr(r4_addr), .req_wdata(r4_wdata),
    .rsp_valid(s4_valid), .rsp_ready(s4_ready),
    .rsp_rdata(s4_rdata), .rsp_err(s4_err),
    .addressVirt(a4), .dataInVirt(di4),
    .wEnVirt(we4), .rstVirt(rv4), .dataOutVirt(d4_dout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: single-cycle word memory, optionally overridden to disturb reads.
  logic [31:0] bus_mem [256];
  logic        bus_ovr;
  logic [31:0] bus_val;
  always @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 256; i++) bus_mem[i] <= '0;
    end else if (wEnVirt) begin
      bus_mem[addressVirt[9:2]] <= dataInVirt;
    end
  end
  always_comb begin
    dataOutVirt = bus_ovr ? bus_val : bus_mem[addressVirt[9:2]];
  end

  // Transaction-level reference: memory contents keyed by word address.
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t        exp_q [$];
  logic [31:0] ref_mem [int unsigned];
  int          wen_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] wen_addr, wen_data;

  function automatic rsp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    rsp_t r;
    int unsigned word = addr / 4;
    if (addr % 4 != 0) begin
      r.rdata = '0; r.err = 1'b1;
    end else if (we) begin
      ref_mem[word] = wdata;
      r.rdata = '0; r.err = 1'b0;
    end else begin
      r.rdata = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
      r.err = 1'b0;
    end
    return r;
  endfunction

  always begin
    rsp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      ref_mem.delete();
    end else begin
      if (wEnVirt) begin
        wen_cnt++;
        wen_addr = addressVirt;
        wen_data = dataInVirt;
      end
      if (rsp_valid && rsp_ready) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_rdata", rsp_rdata, e.rdata);
          chk("sb_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
      if (req_valid && req_ready) exp_q.push_back(model(req_we, req_addr, req_wdata));
    end
  end

  logic [31:0] exp_bus_addr = '0;
  logic [31:0] exp_bus_data = '0;

  // Called at a falling edge with the DUT idle; returns at a falling edge idle.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input logic tbl, input logic [31:0] t_rdata,
                        input logic t_err);
    int n;
    int wen0 = wen_cnt;
    logic aligned = (addr % 4 == 0);
    int exp_lat = !aligned ? 0 : 1;
    logic [31:0] held;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom_range(0, 1);
    req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (!rsp_valid && n < 20) begin
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, exp_lat);
    if (tbl) begin
      chk("tbl_rdata", rsp_rdata, t_rdata);
      chk("tbl_err", {31'b0, rsp_err}, {31'b0, t_err});
    end
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      bus_ovr = 1'b1; bus_val = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, held);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    bus_ovr = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {31'b0, rsp_valid}, 32'd0);
    chk("ready_again", {31'b0, req_ready}, 32'd1);
    if (aligned) exp_bus_addr = addr;
    if (aligned && we) exp_bus_data = wdata;
    chk("wen_pulses", wen_cnt - wen0, (aligned && we) ? 1 : 0);
    if (aligned && we) begin
      chk("wen_addr", wen_addr, addr);
      chk("wen_data", wen_data, wdata);
    end
    chk("bus_addr_hold", addressVirt, exp_bus_addr);
    chk("bus_data_hold", dataInVirt, exp_bus_data);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d4_seq [4];
    int n;
    int r0;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         0, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0022, 32'h1111_2222, 1, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 0, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,         5, 32'h1234_5678, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0030, 32'h0,         2, 32'h0, 1'b0};

    rst = 1'b1; bus_ovr = 1'b0; bus_val = '0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    r4_valid = 1'b0; r4_we = 1'b0; r4_addr = '0; r4_wdata = '0; s4_ready = 1'b0;
    d4_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_addr", addressVirt, 32'h0);
    chk("rst_wdata", dataInVirt, 32'h0);
    chk("rst_wen", {31'b0, wEnVirt}, 32'd0);
    chk("rst_rstvirt", {31'b0, rstVirt}, 32'd1);
    chk("rst4_rsp_valid", {31'b0, s4_valid}, 32'd0);
    rst = 1'b0;
    #1 chk("rstvirt_low", {31'b0, rstVirt}, 32'd0);
    @(negedge clk);

    foreach (vecs[i])
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, 1'b1,
             vecs[i].exp_rdata, vecs[i].exp_err);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = {22'b0, 10'($urandom)};
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      do_txn(1'($urandom), a, $urandom, $urandom_range(0, 3), 1'b0, '0, 1'b0);
    end

    // Back-to-back alternating store/load with the consumer always ready.
    r0 = resp_cnt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_we = (i % 2 == 0);
      req_addr = 32'h100 + 32'((i / 2) * 4);
      req_wdata = 32'hC0DE_0000 + 32'(i);
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_accept_wait", {31'b0, n >= 20}, 32'd0);
      if (req_we) exp_bus_data = req_wdata;
      exp_bus_addr = req_addr;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_rsp_count", resp_cnt - r0, 8);
    chk("b2b_queue_empty", exp_q.size(), 0);
    chk("b2b_bus_addr", addressVirt, exp_bus_addr);

    // Reset in the middle of a load: the load is dropped without a response.
    r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_in_flight", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    #1 chk("mid_rstvirt", {31'b0, rstVirt}, 32'd1);
    @(negedge clk);
    chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_addr", addressVirt, 32'h0);
    chk("mid_wdata", dataInVirt, 32'h0);
    chk("mid_rdata", rsp_rdata, 32'h0);
    chk("mid_wen", {31'b0, wEnVirt}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;
    chk("mid_rsp_count", resp_cnt - r0, 0);
    exp_bus_addr = '0; exp_bus_data = '0;

    // READ_LATENCY = 4: only the value on the bus in the 4th wait cycle lands.
    d4_seq[0] = 32'h1111_0001; d4_seq[1] = 32'h2222_0002;
    d4_seq[2] = 32'hBAD0_0003; d4_seq[3] = 32'hA5A5_A5A5;
    r4_valid = 1'b1; r4_we = 1'b0; r4_addr = 32'h0000_0040;
    chk("l4_ready", {31'b0, r4_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      r4_valid = 1'b0; r4_addr = $urandom;
      d4_dout = d4_seq[k];
      chk("l4_addr", a4, 32'h0000_0040);
      chk("l4_not_yet", {31'b0, s4_valid}, 32'd0);
      chk("l4_wen", {31'b0, we4}, 32'd0);
    end
    @(negedge clk);
    d4_dout = 32'h5555_5555;
    chk("l4_valid", {31'b0, s4_valid}, 32'd1);
    chk("l4_rdata", s4_rdata, 32'hA5A5_A5A5);
    chk("l4_err", {31'b0, s4_err}, 32'd0);
    @(negedge clk);
    chk("l4_rdata_stable", s4_rdata, 32'hA5A5_A5A5);
    s4_ready = 1'b1;
    @(negedge clk);
    s4_ready = 1'b0;
    chk("l4_done", {31'b0, s4_valid}, 32'd0);
    chk("l4_ready_again", {31'b0, r4_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
